// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: packet widths, packet layout
// and source encodings.
package wb_arbiter_pkg;

    localparam int DataWidth    = 32;
    localparam int TotalNumBank = 8;
    localparam int AddrWidth    = 5;
    localparam int FlagsWidth   = 20;

    localparam int WB_PAYLOAD_W = 1 + 4 + TotalNumBank + AddrWidth + 4*DataWidth + FlagsWidth;

    // Field order (MSB first) fixes the packing used by the FIFO and output register.
    typedef struct packed {
        logic                    sat;
        logic [3:0]              mask;
        logic [TotalNumBank-1:0] wen;
        logic [AddrWidth-1:0]    addr;
        logic [4*DataWidth-1:0]  res;
        logic [FlagsWidth-1:0]   flags;
    } wb_pkt_t;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU/LSU writeback streams and the arbitrated output packet.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                    alu_valid;
    logic                    alu_des_sat;
    logic [3:0]              alu_des_mask;
    logic [TotalNumBank-1:0] alu_writeEn;
    logic [AddrWidth-1:0]    alu_writeAddr;
    logic [4*DataWidth-1:0]  alu_res;
    logic [FlagsWidth-1:0]   alu_flags;
    logic                    alu_stall;

    logic                    lsu_valid;
    logic                    lsu_ready;
    logic                    lsu_des_sat;
    logic [3:0]              lsu_des_mask;
    logic [TotalNumBank-1:0] lsu_writeEn;
    logic [AddrWidth-1:0]    lsu_writeAddr;
    logic [4*DataWidth-1:0]  lsu_res;
    logic [FlagsWidth-1:0]   lsu_flags;

    logic                    wb_valid;
    logic                    wb_src;
    logic                    des_sat_w;
    logic [3:0]              des_mask_w;
    logic [TotalNumBank-1:0] writeEn_w;
    logic [AddrWidth-1:0]    writeAddr_w;
    logic [4*DataWidth-1:0]  res_w;
    logic [FlagsWidth-1:0]   flags_w;
    logic                    ovf_err;

    modport master (
        output alu_valid, alu_des_sat, alu_des_mask, alu_writeEn, alu_writeAddr, alu_res, alu_flags,
        output lsu_valid, lsu_des_sat, lsu_des_mask, lsu_writeEn, lsu_writeAddr, lsu_res, lsu_flags,
        input  alu_stall, lsu_ready,
        input  wb_valid, wb_src, des_sat_w, des_mask_w, writeEn_w, writeAddr_w, res_w, flags_w, ovf_err
    );

    modport slave (
        input  alu_valid, alu_des_sat, alu_des_mask, alu_writeEn, alu_writeAddr, alu_res, alu_flags,
        input  lsu_valid, lsu_des_sat, lsu_des_mask, lsu_writeEn, lsu_writeAddr, lsu_res, lsu_flags,
        output alu_stall, lsu_ready,
        output wb_valid, wb_src, des_sat_w, des_mask_w, writeEn_w, writeAddr_w, res_w, flags_w, ovf_err
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding ALU packets that lost arbitration.
// A push while full with no pop in the same cycle is discarded.
module wb_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [Width-1:0]             din,
    output logic [Width-1:0]             head,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth+1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between the ALU and LSU writeback streams.
// ALU has priority; an anti-starvation counter periodically hands the slot to the LSU.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int AluFifoDepth = 4,
    parameter int AluInflight  = 2,
    parameter int StarveLimit  = 7
) (
    input  logic         clk,
    input  logic         rstn,
    wb_arbiter_if.slave  bus
);
    localparam int CntW = $clog2(AluFifoDepth+1);
    localparam int StW  = $clog2(StarveLimit+1);

    wb_pkt_t         alu_pkt, lsu_pkt, fifo_head, alu_cand;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            alu_cand_valid, alu_grant, lsu_grant;

    logic [StW-1:0]  starve_q, starve_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_src_q, wb_src_d;
    wb_pkt_t         wb_pkt_q, wb_pkt_d;
    logic            ovf_q, ovf_d;

    assign alu_pkt = {bus.alu_des_sat, bus.alu_des_mask, bus.alu_writeEn,
                      bus.alu_writeAddr, bus.alu_res, bus.alu_flags};
    assign lsu_pkt = {bus.lsu_des_sat, bus.lsu_des_mask, bus.lsu_writeEn,
                      bus.lsu_writeAddr, bus.lsu_res, bus.lsu_flags};

    wb_fifo #(.Width(WB_PAYLOAD_W), .Depth(AluFifoDepth)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (alu_pkt),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The FIFO head always precedes the live packet so ALU order is preserved.
    always_comb begin
        alu_cand_valid = !fifo_empty || bus.alu_valid;
        alu_cand       = fifo_empty ? alu_pkt : fifo_head;
        lsu_grant      = bus.lsu_valid && (!alu_cand_valid || starve_q == StW'(StarveLimit));
        alu_grant      = alu_cand_valid && !lsu_grant;
        fifo_pop       = alu_grant && !fifo_empty;
        fifo_push      = bus.alu_valid && !(alu_grant && fifo_empty);
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.lsu_valid || lsu_grant) begin
            starve_d = '0;
        end else if (starve_q != StW'(StarveLimit)) begin
            starve_d = starve_q + StW'(1);
        end

        wb_valid_d = alu_grant || lsu_grant;
        wb_src_d   = wb_src_q;
        wb_pkt_d   = wb_pkt_q;
        if (lsu_grant) begin
            wb_src_d = WB_SRC_LSU;
            wb_pkt_d = lsu_pkt;
        end else if (alu_grant) begin
            wb_src_d = WB_SRC_ALU;
            wb_pkt_d = alu_cand;
        end

        ovf_d = ovf_q || (fifo_push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_src_q   <= 1'b0;
            wb_pkt_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            wb_valid_q <= wb_valid_d;
            wb_src_q   <= wb_src_d;
            wb_pkt_q   <= wb_pkt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.lsu_ready   = lsu_grant;
    assign bus.alu_stall   = (fifo_count >= CntW'(AluFifoDepth - AluInflight));
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_src      = wb_src_q;
    assign bus.des_sat_w   = wb_pkt_q.sat;
    assign bus.des_mask_w  = wb_pkt_q.mask;
    assign bus.writeEn_w   = wb_pkt_q.wen;
    assign bus.writeAddr_w = wb_pkt_q.addr;
    assign bus.res_w       = wb_pkt_q.res;
    assign bus.flags_w     = wb_pkt_q.flags;
    assign bus.ovf_err     = ovf_q;

endmodule
